// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive and transmit paths.
// Also provides the 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

  localparam int UART_BAUD_DIV_DEFAULT = 868;
  localparam int UART_DATA_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous line.
// Both flops are preset high so an idle-high line reads as idle out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits, LSB first, one stop bit, BAUD_DIV clocks per bit.
// Define UART_RX_MAJORITY_EN to vote each sample over three adjacent cycles.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_frame_err,
  output logic                   rx_busy
);

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_LAT = 1;
`else
  localparam int MAJ_LAT = 0;
`endif

  // With voting, each decision waits one cycle so the sample point +1 is available.
  localparam logic [15:0] HALF_END = 16'(BAUD_DIV / 2 - 1 + MAJ_LAT);
  localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);

  logic rx_s;
  logic sample_s;

  uart_state_e            state_q,        state_d;
  logic [15:0]            baud_cnt_q,     baud_cnt_d;
  logic [2:0]             bit_idx_q,      bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q,        shift_d;
  logic [UART_DATA_W-1:0] rx_data_q,      rx_data_d;
  logic                   rx_valid_q,     rx_valid_d;
  logic                   rx_frame_err_q, rx_frame_err_d;
  logic                   rx_busy_q,      rx_busy_d;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic rx_h1_q;
  logic rx_h2_q;

  // two-cycle history of rx_s for the vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_h1_q <= 1'b1;
      rx_h2_q <= 1'b1;
    end else begin
      rx_h1_q <= rx_s;
      rx_h2_q <= rx_h1_q;
    end
  end

  assign sample_s = maj3(rx_s, rx_h1_q, rx_h2_q);
`else
  assign sample_s = rx_s;
`endif

  // next-state and output decode
  always_comb begin
    state_d        = state_q;
    baud_cnt_d     = baud_cnt_q + 16'd1;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = 16'd0;
        if (!rx_s) state_d = ST_START;
        else       state_d = ST_IDLE;
      end
      ST_START: begin
        if (baud_cnt_q == HALF_END) begin
          baud_cnt_d = 16'd0;
          bit_idx_d  = 3'd0;
          if (!sample_s) state_d = ST_DATA;
          else           state_d = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == BIT_END) begin
          baud_cnt_d = 16'd0;
          shift_d    = {sample_s, shift_q[UART_DATA_W-1:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   state_d = ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud_cnt_q == BIT_END) begin
          baud_cnt_d = 16'd0;
          if (sample_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            state_d        = ST_WAIT_HIGH;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low break parks here so it reports a single error.
        baud_cnt_d = 16'd0;
        if (rx_s) state_d = ST_IDLE;
        else      state_d = ST_WAIT_HIGH;
      end
      default: begin
        baud_cnt_d = 16'd0;
        state_d    = ST_IDLE;
      end
    endcase

    rx_busy_d = (state_d != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      baud_cnt_q     <= 16'd0;
      bit_idx_q      <= 3'd0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      baud_cnt_q     <= baud_cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = rx_busy_q;

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, giving clock cycles per bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port rx_data, output, 8 bits: last correctly framed byte, held until the next good frame.
REQ-006 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-007 SHALL have port rx_frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer, preset high on reset; rx_s denotes its output; all decisions use rx_s only.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a 16-bit baud counter and a 3-bit bit index.
REQ-011 IDLE: on rx_s==0, go to START and clear baud counter.
REQ-012 START: at baud count BAUD_DIV/2-1 (integer divide), rx_s==0 goes to DATA with counter cleared; rx_s==1 is a glitch and returns to IDLE with no output pulse.
REQ-013 DATA: at baud count BAUD_DIV-1, sample one bit, shift it in LSB-first (right shift, new bit at bit 7), clear counter, increment bit index; after the 8th bit (index wraps 7->0), go to STOP.
REQ-014 STOP: at baud count BAUD_DIV-1, a high sample loads rx_data from the shift register, pulses rx_valid on the next cycle, and goes to IDLE.
REQ-015 STOP with a low sample leaves rx_data unchanged, pulses rx_frame_err on the next cycle, and goes to WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_s==1, then IDLE; a held-low line (break) produces exactly one rx_frame_err and no further frames.
REQ-017 rx_valid and rx_frame_err SHALL be mutually exclusive and never high on consecutive cycles for one frame.
REQ-018 Latency: rx_valid SHALL rise 1 clk after the stop-bit sample point, i.e. 9*BAUD_DIV + BAUD_DIV/2 + 1 clk after the rx_s falling edge; add 2 for the synchronizer from rx.
REQ-019 A start edge seen in IDLE on the cycle after a STOP return SHALL be accepted (back-to-back frames, zero idle bits).

Reset
REQ-020 While rst_n==0: state IDLE, counters 0, shift register 0, rx_data 8'h00, rx_valid 0, rx_frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-021 Reset mid-frame SHALL abandon the frame with no pulse; after release, reception restarts only on a new falling edge.

Configuration
REQ-022 With UART_RX_MAJORITY_EN defined, each sample (start, data, stop) SHALL be the 2-of-3 majority of rx_s at sample point -1, 0 and +1 cycles, adding 1 cycle to REQ-018 latency; without it, a single rx_s sample at the sample point is used.

Structure
REQ-023 Package uart_pkg SHALL hold the state enumeration, the default BAUD_DIV constant and the data width (8), shared with the transmitter.
REQ-024 Sub-module uart_sync2 (2-flop synchronizer, async active-low reset to 1) SHALL be instantiated for rx.

Verification (bench BAUD_DIV=16)
REQ-025 Byte 8'hA5 with one stop bit -> single rx_valid pulse, rx_data==8'hA5, rx_frame_err never high.
REQ-026 Bytes 8'h00 then 8'hFF back-to-back, zero idle -> two rx_valid pulses 160 clk apart, data 8'h00 then 8'hFF.
REQ-027 Frame 8'h3C with stop bit forced low, then line high -> one rx_frame_err pulse, rx_data keeps previous value, next 8'h5A frame received correctly.
REQ-028 6-clk low glitch on idle line -> returns to IDLE, no pulse, rx_busy high for at most 10 clk.
REQ-029 rst_n asserted during bit 4 of 8'hC3 -> all outputs at reset values immediately, no pulse; subsequent 8'h81 received correctly.
REQ-030 With UART_RX_MAJORITY_EN, 1-clk inverted spike at each data sample point of 8'h96 -> rx_data==8'h96; without the macro, the same stimulus yields 8'h69.
